operand_buffer: RTL and testbench

- Double-buffered operand store between the host byte interface and the 2x2 systolic array.
- Captures the 8-byte operand set (W0..W3, X0..X3) at the address driven by the control unit.
- Drives the four array operands a0/a1/b0/b1 from the committed bank, using the control unit's per-cycle selects and transpose.
- While the array works on one set, the next set fills the shadow bank; the swap is deferred to a matrix boundary.

---
 rtl/tpu_pkg.sv | 23 ++
 rtl/operand_mux.sv | 41 ++++
 rtl/operand_buffer.sv | 120 ++++++++++++
 tb/tb_operand_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the systolic-array datapath blocks.
// Holds default widths, operand-store address map and operand select encodings.
package tpu_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

    // Operand store address map: weights first, then activations, both row-major
    localparam logic [2:0] ADDR_W0 = 3'd0;
    localparam logic [2:0] ADDR_W1 = 3'd1;
    localparam logic [2:0] ADDR_W2 = 3'd2;
    localparam logic [2:0] ADDR_W3 = 3'd3;
    localparam logic [2:0] ADDR_X0 = 3'd4;
    localparam logic [2:0] ADDR_X1 = 3'd5;
    localparam logic [2:0] ADDR_X2 = 3'd6;
    localparam logic [2:0] ADDR_X3 = 3'd7;

    // Per-cycle operand select encodings; 3 behaves like SEL_ZERO
    localparam logic [1:0] SEL_0    = 2'd0;
    localparam logic [1:0] SEL_1    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

endpackage

// File: rtl/operand_mux.sv
// Select/transpose network for one operand pair of the systolic array.
// out0 picks e0/e1 (e1 swaps to e2 under transpose), out1 picks e2/e3
// (e2 swaps to e1 under transpose). Everything reads zero while en is low.
module operand_mux
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              en,
    input  logic              transpose,
    input  logic [1:0]        sel0,
    input  logic [1:0]        sel1,
    input  logic [DATA_W-1:0] e0,
    input  logic [DATA_W-1:0] e1,
    input  logic [DATA_W-1:0] e2,
    input  logic [DATA_W-1:0] e3,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1
);

    // Pure select network; transpose only swaps the off-diagonal elements
    always_comb begin
        out0 = '0;
        out1 = '0;
        if (en) begin
            case (sel0)
                SEL_0:    out0 = e0;
                SEL_1:    out0 = transpose ? e2 : e1;
                SEL_ZERO: out0 = '0;
                default:  out0 = '0;
            endcase
            case (sel1)
                SEL_0:    out1 = transpose ? e1 : e2;
                SEL_1:    out1 = e3;
                SEL_ZERO: out1 = '0;
                default:  out1 = '0;
            endcase
        end
    end

endmodule

// File: rtl/operand_buffer.sv
// Double-buffered operand store feeding the 2x2 systolic array.
// The host fills the shadow bank byte by byte; a write to the last address
// closes the set, and the bank swap waits for a matrix boundary (clear) or
// happens at once when nothing has been committed yet.
module operand_buffer
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        host_indata,
    input  logic                     clear,
    input  logic                     transpose,
    input  logic [1:0]               a0_sel,
    input  logic [1:0]               a1_sel,
    input  logic [1:0]               b0_sel,
    input  logic [1:0]               b1_sel,
    output logic signed [DATA_W-1:0] a0,
    output logic signed [DATA_W-1:0] a1,
    output logic signed [DATA_W-1:0] b0,
    output logic signed [DATA_W-1:0] b1,
    output logic                     compute_valid,
    output logic                     swap_pulse,
    output logic                     fill_bank,
    output logic                     load_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DEPTH-1:0] CLOSE_BIT = {1'b1, {(DEPTH-1){1'b0}}};

    logic [DATA_W-1:0] bank [2][DEPTH];
    logic [DEPTH-1:0]  mask;
    logic              pending;
    logic              commit_bank;
    logic              commit_now;
    logic              close_ok;
    logic              is_close;

    // A closed set swaps in at a matrix boundary, or immediately if the array is idle
    assign commit_now = pending && (clear || !compute_valid);
    assign close_ok   = &(mask | CLOSE_BIT);
    assign is_close   = (mem_addr == ADDR_W'(ADDR_X3));

    // Bank storage, fill mask, pending flag, commit and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank[b][i] <= '0;
                end
            end
            mask          <= '0;
            pending       <= 1'b0;
            commit_bank   <= 1'b0;
            fill_bank     <= 1'b0;
            compute_valid <= 1'b0;
            swap_pulse    <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            if (load_en) begin
                if (pending) begin
                    load_err <= 1'b1;
                end else begin
                    bank[fill_bank][mem_addr] <= host_indata;
                    if (is_close) begin
                        mask <= '0;
                        if (close_ok) begin
                            pending <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else begin
                        mask[mem_addr] <= 1'b1;
                    end
                end
            end
            if (commit_now) begin
                commit_bank   <= fill_bank;
                fill_bank     <= ~fill_bank;
                pending       <= 1'b0;
                compute_valid <= 1'b1;
                swap_pulse    <= 1'b1;
            end
        end
    end

    // Weight side: a0 from W0/W1, a1 from W2/W3, never transposed
    operand_mux #(.DATA_W(DATA_W)) u_a_mux (
        .en        (compute_valid),
        .transpose (1'b0),
        .sel0      (a0_sel),
        .sel1      (a1_sel),
        .e0        (bank[commit_bank][ADDR_W0]),
        .e1        (bank[commit_bank][ADDR_W1]),
        .e2        (bank[commit_bank][ADDR_W2]),
        .e3        (bank[commit_bank][ADDR_W3]),
        .out0      (a0),
        .out1      (a1)
    );

    // Activation side: b0 from X0/X1, b1 from X2/X3, transpose swaps X1 and X2
    operand_mux #(.DATA_W(DATA_W)) u_b_mux (
        .en        (compute_valid),
        .transpose (transpose),
        .sel0      (b0_sel),
        .sel1      (b1_sel),
        .e0        (bank[commit_bank][ADDR_X0]),
        .e1        (bank[commit_bank][ADDR_X1]),
        .e2        (bank[commit_bank][ADDR_X2]),
        .e3        (bank[commit_bank][ADDR_X3]),
        .out0      (b0),
        .out1      (b1)
    );

endmodule

// File: tb/tb_operand_buffer.sv
// Directed testbench for operand_buffer: fill, select/transpose, deferred swap,
// incomplete-set and pending-write errors, and reset in the middle of a fill.
module tb_operand_buffer;

    logic              clk;
    logic              rst;
    logic              load_en;
    logic [2:0]        mem_addr;
    logic [7:0]        host_indata;
    logic              clear;
    logic              transpose;
    logic [1:0]        a0_sel, a1_sel, b0_sel, b1_sel;
    logic signed [7:0] a0, a1, b0, b1;
    logic              compute_valid, swap_pulse, fill_bank, load_err;

    int checks   = 0;
    int failures = 0;

    operand_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .mem_addr      (mem_addr),
        .host_indata   (host_indata),
        .clear         (clear),
        .transpose     (transpose),
        .a0_sel        (a0_sel),
        .a1_sel        (a1_sel),
        .b0_sel        (b0_sel),
        .b1_sel        (b1_sel),
        .a0            (a0),
        .a1            (a1),
        .b0            (b0),
        .b1            (b1),
        .compute_valid (compute_valid),
        .swap_pulse    (swap_pulse),
        .fill_bank     (fill_bank),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle so outputs reflect that edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [2:0] addr, input logic [7:0] data);
        load_en     = 1'b1;
        mem_addr    = addr;
        host_indata = data;
        tick();
        load_en     = 1'b0;
    endtask

    task automatic set_sels(input logic [1:0] s, input logic t);
        a0_sel = s; a1_sel = s; b0_sel = s; b1_sel = s; transpose = t;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; mem_addr = '0; host_indata = '0; clear = 1'b0;
        set_sels(2'd0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (compute_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cv got=%0b exp=0", compute_valid); end
        checks++; if (swap_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_swap got=%0b exp=0", swap_pulse); end
        checks++; if (fill_bank !== 1'b0) begin failures++; $display("[TB] FAIL reset_fill_bank got=%0b exp=0", fill_bank); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_err got=%0b exp=0", load_err); end
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin failures++; $display("[TB] FAIL reset_operands got=%h exp=0", {a0, a1, b0, b1}); end
    endtask

    task automatic test_fill_basic();
        for (int i = 0; i < 8; i++) write_byte(3'(i), 8'(i + 1));
        checks++; if (compute_valid !== 1'b0) begin failures++; $display("[TB] FAIL fill_cv_early got=%0b exp=0", compute_valid); end
        tick();
        checks++; if (compute_valid !== 1'b1) begin failures++; $display("[TB] FAIL fill_cv got=%0b exp=1", compute_valid); end
        checks++; if (swap_pulse !== 1'b1) begin failures++; $display("[TB] FAIL fill_swap got=%0b exp=1", swap_pulse); end
        checks++; if (fill_bank !== 1'b1) begin failures++; $display("[TB] FAIL fill_bank_toggle got=%0b exp=1", fill_bank); end
        tick();
        checks++; if (swap_pulse !== 1'b0) begin failures++; $display("[TB] FAIL fill_swap_one_cycle got=%0b exp=0", swap_pulse); end
        checks++; if ({a0, a1, b0, b1} !== 32'h01030507) begin failures++; $display("[TB] FAIL fill_sel0 got=%h exp=01030507", {a0, a1, b0, b1}); end
    endtask

    task automatic test_select_transpose();
        set_sels(2'd1, 1'b0);
        checks++; if ({a0, a1, b0, b1} !== 32'h02040608) begin failures++; $display("[TB] FAIL sel1_t0 got=%h exp=02040608", {a0, a1, b0, b1}); end
        set_sels(2'd1, 1'b1);
        checks++; if ({a0, a1, b0, b1} !== 32'h02040708) begin failures++; $display("[TB] FAIL sel1_t1 got=%h exp=02040708", {a0, a1, b0, b1}); end
        set_sels(2'd0, 1'b1);
        checks++; if ({a0, a1, b0, b1} !== 32'h01030506) begin failures++; $display("[TB] FAIL sel0_t1 got=%h exp=01030506", {a0, a1, b0, b1}); end
        set_sels(2'd2, 1'b0);
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin failures++; $display("[TB] FAIL sel2_zero got=%h exp=0", {a0, a1, b0, b1}); end
        set_sels(2'd3, 1'b1);
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin failures++; $display("[TB] FAIL sel3_zero got=%h exp=0", {a0, a1, b0, b1}); end
        set_sels(2'd0, 1'b0);
    endtask

    task automatic test_double_buffer();
        for (int i = 0; i < 8; i++) write_byte(3'(i), 8'(8'h81 + i));
        tick(); tick();
        checks++; if ({a0, a1, b0, b1} !== 32'h01030507) begin failures++; $display("[TB] FAIL hold_old_set got=%h exp=01030507", {a0, a1, b0, b1}); end
        checks++; if (swap_pulse !== 1'b0) begin failures++; $display("[TB] FAIL hold_no_swap got=%0b exp=0", swap_pulse); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (a0 !== -8'sd127) begin failures++; $display("[TB] FAIL swap_a0 got=%0d exp=-127", a0); end
        checks++; if ({a1, b0, b1} !== 24'h838587) begin failures++; $display("[TB] FAIL swap_rest got=%h exp=838587", {a1, b0, b1}); end
        checks++; if (swap_pulse !== 1'b1) begin failures++; $display("[TB] FAIL swap_pulse got=%0b exp=1", swap_pulse); end
        checks++; if (fill_bank !== 1'b0) begin failures++; $display("[TB] FAIL swap_fill_bank got=%0b exp=0", fill_bank); end
    endtask

    task automatic test_pending_reject();
        for (int i = 0; i < 8; i++) write_byte(3'(i), 8'(8'h20 + i));
        checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL pend_no_err got=%0b exp=0", load_err); end
        write_byte(3'd3, 8'h99);
        checks++; if (load_err !== 1'b1) begin failures++; $display("[TB] FAIL pend_reject_err got=%0b exp=1", load_err); end
        checks++; if (a0 !== 8'sh81) begin failures++; $display("[TB] FAIL pend_old_a0 got=%h exp=81", a0); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_sels(2'd1, 1'b0);
        checks++; if (a1 !== 8'sh23) begin failures++; $display("[TB] FAIL pend_w3_kept got=%h exp=23", a1); end
        checks++; if (fill_bank !== 1'b1) begin failures++; $display("[TB] FAIL pend_fill_bank got=%0b exp=1", fill_bank); end
        set_sels(2'd0, 1'b0);
    endtask

    task automatic test_incomplete();
        do_reset();
        write_byte(3'd0, 8'h30);
        write_byte(3'd1, 8'h31);
        write_byte(3'd2, 8'h32);
        write_byte(3'd7, 8'h37);
        checks++; if (load_err !== 1'b1) begin failures++; $display("[TB] FAIL incomplete_err got=%0b exp=1", load_err); end
        tick(); tick();
        checks++; if (compute_valid !== 1'b0) begin failures++; $display("[TB] FAIL incomplete_no_commit got=%0b exp=0", compute_valid); end
        for (int i = 0; i < 8; i++) write_byte(3'(i), 8'(8'h30 + i));
        tick();
        checks++; if (compute_valid !== 1'b1) begin failures++; $display("[TB] FAIL refill_cv got=%0b exp=1", compute_valid); end
        checks++; if ({a0, a1, b0, b1} !== 32'h30323436) begin failures++; $display("[TB] FAIL refill_ops got=%h exp=30323436", {a0, a1, b0, b1}); end
        checks++; if (load_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%0b exp=1", load_err); end
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 4; i++) write_byte(3'(i), 8'(8'h50 + i));
        rst = 1'b1;
        write_byte(3'd4, 8'h54);
        rst = 1'b0;
        checks++; if ({a0, a1, b0, b1} !== 32'h0) begin failures++; $display("[TB] FAIL midrst_ops got=%h exp=0", {a0, a1, b0, b1}); end
        checks++; if ({compute_valid, fill_bank, load_err, swap_pulse} !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_flags got=%b exp=0000", {compute_valid, fill_bank, load_err, swap_pulse}); end
        for (int i = 0; i < 8; i++) write_byte(3'(i), 8'(8'h40 + i));
        tick();
        checks++; if ({a0, a1, b0, b1} !== 32'h40424446) begin failures++; $display("[TB] FAIL fresh_ops got=%h exp=40424446", {a0, a1, b0, b1}); end
        checks++; if ({compute_valid, fill_bank, load_err} !== 3'b110) begin failures++; $display("[TB] FAIL fresh_flags got=%b exp=110", {compute_valid, fill_bank, load_err}); end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_select_transpose();
        test_double_buffer();
        test_pending_reject();
        test_incomplete();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
